// File: rtl/int8_mac_cvxif_issuer_if.sv
// int8_mac_cvxif_issuer_if
// Bundles the issuer's request, CVXIF issue/register/commit/result and
// writeback/status signals. Signal names carry the _i/_o suffix as seen
// from the issuer.
//   master : core side + coprocessor model (drives *_i, observes *_o)
//   slave  : the issuer itself (drives *_o, observes *_i)
interface int8_mac_cvxif_issuer_if #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned HartidWidth    = 1,
    parameter int unsigned MaxOutstanding = 4
) ();
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    // core request
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [31:0]            req_instr_i;
    logic [XLEN-1:0]        req_rs1_i;
    logic [XLEN-1:0]        req_rs2_i;
    logic [HartidWidth-1:0] req_hartid_i;
    // CVXIF issue / register
    logic                   x_issue_valid_o;
    logic                   x_issue_ready_i;
    logic [31:0]            x_issue_instr_o;
    logic [HartidWidth-1:0] x_issue_hartid_o;
    logic [IdWidth-1:0]     x_issue_id_o;
    logic                   x_issue_accept_i;
    logic                   x_issue_writeback_i;
    logic                   x_register_valid_o;
    logic [2*XLEN-1:0]      x_register_rs_o;
    // CVXIF commit
    logic                   x_commit_valid_o;
    logic [IdWidth-1:0]     x_commit_id_o;
    logic                   x_commit_kill_o;
    // CVXIF result
    logic                   x_result_valid_i;
    logic [IdWidth-1:0]     x_result_id_i;
    logic [XLEN-1:0]        x_result_data_i;
    logic [4:0]             x_result_rd_i;
    logic                   x_result_we_i;
    // writeback and status
    logic                   wb_valid_o;
    logic [4:0]             wb_rd_o;
    logic [XLEN-1:0]        wb_data_o;
    logic [IdWidth-1:0]     wb_id_o;
    logic                   rej_o;
    logic                   spurious_o;
    logic [CntWidth-1:0]    outstanding_o;
    logic                   timeout_o;

    modport master (
        output req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_hartid_i,
        output x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
        output x_result_valid_i, x_result_id_i, x_result_data_i, x_result_rd_i, x_result_we_i,
        input  req_ready_o,
        input  x_issue_valid_o, x_issue_instr_o, x_issue_hartid_o, x_issue_id_o,
        input  x_register_valid_o, x_register_rs_o,
        input  x_commit_valid_o, x_commit_id_o, x_commit_kill_o,
        input  wb_valid_o, wb_rd_o, wb_data_o, wb_id_o,
        input  rej_o, spurious_o, outstanding_o, timeout_o
    );

    modport slave (
        input  req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_hartid_i,
        input  x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
        input  x_result_valid_i, x_result_id_i, x_result_data_i, x_result_rd_i, x_result_we_i,
        output req_ready_o,
        output x_issue_valid_o, x_issue_instr_o, x_issue_hartid_o, x_issue_id_o,
        output x_register_valid_o, x_register_rs_o,
        output x_commit_valid_o, x_commit_id_o, x_commit_kill_o,
        output wb_valid_o, wb_rd_o, wb_data_o, wb_id_o,
        output rej_o, spurious_o, outstanding_o, timeout_o
    );
endinterface

// File: rtl/int8_mac_cvxif_issuer.sv
// int8_mac_cvxif_issuer
// Core-side initiator of the CVXIF link to int8_mac_coprocessor. Accepts one
// request at a time, runs issue -> commit handshakes, tracks writeback-pending
// ids in a bitmap and turns returned results into registered writeback pulses.
// Results are always sunk (no backpressure on the result channel).
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : int8_mac_cvxif_issuer_if.slave (request, CVXIF, writeback, status)
// Optional feature: define INT8_MAC_ISSUER_TIMEOUT_EN to enable the sticky
// watchdog (timeout_o); otherwise timeout_o is tied to 0.
module int8_mac_cvxif_issuer #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned HartidWidth    = 1,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 256
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    int8_mac_cvxif_issuer_if.slave bus
);
    localparam int unsigned NumIds   = 2 ** IdWidth;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    if (MaxOutstanding < 1 || MaxOutstanding > NumIds) begin : g_bad_max_outstanding
        $error("MaxOutstanding must lie in 1..2**IdWidth");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            instr_q, instr_d;
    logic [XLEN-1:0]        rs1_q, rs1_d, rs2_q, rs2_d;
    logic [HartidWidth-1:0] hartid_q, hartid_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic                   accept_q, accept_d;
    logic                   wback_q, wback_d;
    logic [NumIds-1:0]      pending_q, pending_d;
    logic [IdWidth-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic [CntWidth-1:0]    count_q, count_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]        wb_data_q, wb_data_d;
    logic [IdWidth-1:0]     wb_id_q, wb_id_d;
    logic                   spurious_q, spurious_d;

    logic req_ready, issue_valid, commit_valid, commit_kill, rej;
    logic set_pend, res_hit;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        hartid_d    = hartid_q;
        id_d        = id_q;
        accept_d    = accept_q;
        wback_d     = wback_q;
        pending_d   = pending_q;
        alloc_ptr_d = alloc_ptr_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_id_d     = wb_id_q;
        spurious_d  = 1'b0;
        req_ready    = 1'b0;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
        rej          = 1'b0;
        set_pend     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // An id is only handed out if it is not still awaiting its result.
                if (bus.req_valid_i && (count_q < MaxCnt) && !pending_q[alloc_ptr_q]) begin
                    req_ready = 1'b1;
                    instr_d   = bus.req_instr_i;
                    rs1_d     = bus.req_rs1_i;
                    rs2_d     = bus.req_rs2_i;
                    hartid_d  = bus.req_hartid_i;
                    id_d      = alloc_ptr_q;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                issue_valid = 1'b1;
                if (bus.x_issue_ready_i) begin
                    accept_d = bus.x_issue_accept_i;
                    wback_d  = bus.x_issue_writeback_i;
                    state_d  = StCommit;
                end
            end
            StCommit: begin
                commit_valid = 1'b1;
                commit_kill  = ~accept_q;
                rej          = ~accept_q;
                if (accept_q) begin
                    alloc_ptr_d = alloc_ptr_q + IdWidth'(1);
                    if (wback_q) begin
                        pending_d[id_q] = 1'b1;
                        set_pend        = 1'b1;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Result channel is serviced in every state. A hit can never target the
        // id being set above, since that id was not pending when allocated.
        res_hit = bus.x_result_valid_i && pending_q[bus.x_result_id_i];
        if (res_hit) begin
            pending_d[bus.x_result_id_i] = 1'b0;
            wb_valid_d = bus.x_result_we_i;
            if (bus.x_result_we_i) begin
                wb_rd_d   = bus.x_result_rd_i;
                wb_data_d = bus.x_result_data_i;
                wb_id_d   = bus.x_result_id_i;
            end
        end
        spurious_d = bus.x_result_valid_i && !pending_q[bus.x_result_id_i];

        unique case ({set_pend, res_hit})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            hartid_q    <= '0;
            id_q        <= '0;
            accept_q    <= 1'b0;
            wback_q     <= 1'b0;
            pending_q   <= '0;
            alloc_ptr_q <= '0;
            count_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_id_q     <= '0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            hartid_q    <= hartid_d;
            id_q        <= id_d;
            accept_q    <= accept_d;
            wback_q     <= wback_d;
            pending_q   <= pending_d;
            alloc_ptr_q <= alloc_ptr_d;
            count_q     <= count_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_id_q     <= wb_id_d;
            spurious_q  <= spurious_d;
        end
    end

`ifdef INT8_MAC_ISSUER_TIMEOUT_EN
    localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);
    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TimeoutCycles);

    logic [WdWidth-1:0] wd_cnt_q, wd_cnt_d;
    logic               timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if ((count_q == '0) || res_hit) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WdLimit) begin
            wd_cnt_d = wd_cnt_q + WdWidth'(1);
        end
        if (wd_cnt_d == WdLimit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.req_ready_o        = req_ready;
    assign bus.x_issue_valid_o    = issue_valid;
    assign bus.x_register_valid_o = issue_valid;
    assign bus.x_issue_instr_o    = instr_q;
    assign bus.x_issue_hartid_o   = hartid_q;
    assign bus.x_issue_id_o       = id_q;
    assign bus.x_register_rs_o    = {rs2_q, rs1_q};
    assign bus.x_commit_valid_o   = commit_valid;
    assign bus.x_commit_id_o      = id_q;
    assign bus.x_commit_kill_o    = commit_kill;
    assign bus.wb_valid_o         = wb_valid_q;
    assign bus.wb_rd_o            = wb_rd_q;
    assign bus.wb_data_o          = wb_data_q;
    assign bus.wb_id_o            = wb_id_q;
    assign bus.rej_o              = rej;
    assign bus.spurious_o         = spurious_q;
    assign bus.outstanding_o      = count_q;
endmodule

// File: tb/tb_int8_mac_cvxif_issuer.sv
// Bench for int8_mac_cvxif_issuer: directed scenarios followed by a random
// mix of issues and results, checked against a bitmap/counter reference.
module tb_int8_mac_cvxif_issuer;
    localparam int unsigned MAXO = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // reference model: set of pending ids, their count, next id to allocate
    bit         m_pending [8];
    int         m_count;
    logic [2:0] m_alloc;

    int8_mac_cvxif_issuer_if #(.XLEN(32), .IdWidth(3), .HartidWidth(1), .MaxOutstanding(MAXO)) bus ();

    int8_mac_cvxif_issuer #(
        .XLEN(32), .IdWidth(3), .HartidWidth(1), .MaxOutstanding(MAXO), .TimeoutCycles(8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid_i         = 1'b0;
        bus.req_instr_i         = '0;
        bus.req_rs1_i           = '0;
        bus.req_rs2_i           = '0;
        bus.req_hartid_i        = '0;
        bus.x_issue_ready_i     = 1'b0;
        bus.x_issue_accept_i    = 1'b0;
        bus.x_issue_writeback_i = 1'b0;
        bus.x_result_valid_i    = 1'b0;
        bus.x_result_id_i       = '0;
        bus.x_result_data_i     = '0;
        bus.x_result_rd_i       = '0;
        bus.x_result_we_i       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        foreach (m_pending[i]) m_pending[i] = 1'b0;
        m_count = 0;
        m_alloc = '0;
        #1;
        chk("rst_issue_valid", bus.x_issue_valid_o, 0);
        chk("rst_register_valid", bus.x_register_valid_o, 0);
        chk("rst_commit_valid", bus.x_commit_valid_o, 0);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        chk("rst_rej", bus.rej_o, 0);
        chk("rst_spurious", bus.spurious_o, 0);
        chk("rst_outstanding", bus.outstanding_o, 0);
        chk("rst_timeout", bus.timeout_o, 0);
        chk("rst_issue_id", bus.x_issue_id_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_commit_valid", bus.x_commit_valid_o, 0);
        chk("post_rst_issue_valid", bus.x_issue_valid_o, 0);
        chk("post_rst_outstanding", bus.outstanding_o, 0);
    endtask

    task automatic check_res(input bit hit, input bit we, input logic [31:0] data,
                             input logic [4:0] rd, input logic [2:0] id);
        chk("wb_valid", bus.wb_valid_o, hit && we);
        chk("spurious", bus.spurious_o, !hit);
        if (hit && we) begin
            chk("wb_data", bus.wb_data_o, data);
            chk("wb_rd", bus.wb_rd_o, rd);
            chk("wb_id", bus.wb_id_o, id);
        end
        chk("outstanding", bus.outstanding_o, m_count);
    endtask

    task automatic do_result(input logic [2:0] id, input bit we, input logic [31:0] data);
        logic [4:0] rd;
        bit hit;
        rd = 5'($urandom);
        bus.x_result_valid_i = 1'b1;
        bus.x_result_id_i    = id;
        bus.x_result_data_i  = data;
        bus.x_result_rd_i    = rd;
        bus.x_result_we_i    = we;
        tick();
        bus.x_result_valid_i = 1'b0;
        bus.x_result_we_i    = 1'b0;
        hit = m_pending[id];
        if (hit) begin
            m_pending[id] = 1'b0;
            m_count--;
        end
        check_res(hit, we, data, rd, id);
        tick();
        chk("wb_valid_pulse_end", bus.wb_valid_o, 0);
        chk("spurious_pulse_end", bus.spurious_o, 0);
    endtask

    // One request through issue/commit; optionally presents a result during the
    // commit cycle to exercise simultaneous pending set and clear.
    task automatic do_issue(input bit acc, input bit wbk, input int unsigned stall,
                            input bit co_res, input logic [2:0] co_id,
                            input logic [31:0] rs1, input logic [31:0] rs2);
        logic [31:0] instr, rdata;
        logic [4:0]  rrd;
        logic        hart;
        logic [2:0]  eid;
        bit          exp_rdy, hit;
        instr = $urandom;
        hart  = 1'($urandom);
        exp_rdy = (m_count < MAXO) && !m_pending[m_alloc];
        bus.req_valid_i  = 1'b1;
        bus.req_instr_i  = instr;
        bus.req_rs1_i    = rs1;
        bus.req_rs2_i    = rs2;
        bus.req_hartid_i = hart;
        #1;
        chk("req_ready", bus.req_ready_o, exp_rdy);
        tick();
        bus.req_valid_i = 1'b0;
        if (!exp_rdy) begin
            chk("no_issue_when_blocked", bus.x_issue_valid_o, 0);
            return;
        end
        eid = m_alloc;
        chk("issue_valid", bus.x_issue_valid_o, 1);
        chk("register_valid", bus.x_register_valid_o, 1);
        chk("issue_id", bus.x_issue_id_o, eid);
        chk("issue_instr", bus.x_issue_instr_o, instr);
        chk("issue_hartid", bus.x_issue_hartid_o, hart);
        chk("register_rs", bus.x_register_rs_o, {rs2, rs1});
        chk("commit_in_issue", bus.x_commit_valid_o, 0);
        for (int unsigned s = 0; s < stall; s++) begin
            tick();
            chk("issue_hold_valid", bus.x_issue_valid_o, 1);
            chk("issue_hold_instr", bus.x_issue_instr_o, instr);
        end
        bus.x_issue_ready_i     = 1'b1;
        bus.x_issue_accept_i    = acc;
        bus.x_issue_writeback_i = wbk;
        tick();
        bus.x_issue_ready_i     = 1'b0;
        bus.x_issue_accept_i    = 1'b0;
        bus.x_issue_writeback_i = 1'b0;
        chk("commit_valid", bus.x_commit_valid_o, 1);
        chk("commit_id", bus.x_commit_id_o, eid);
        chk("commit_kill", bus.x_commit_kill_o, !acc);
        chk("rej", bus.rej_o, !acc);
        chk("issue_valid_in_commit", bus.x_issue_valid_o, 0);
        rdata = $urandom;
        rrd   = 5'($urandom);
        if (co_res) begin
            bus.x_result_valid_i = 1'b1;
            bus.x_result_id_i    = co_id;
            bus.x_result_data_i  = rdata;
            bus.x_result_rd_i    = rrd;
            bus.x_result_we_i    = 1'b1;
        end
        tick();
        bus.x_result_valid_i = 1'b0;
        bus.x_result_we_i    = 1'b0;
        hit = co_res && m_pending[co_id];
        if (acc) begin
            if (wbk) begin
                m_pending[eid] = 1'b1;
                m_count++;
            end
            m_alloc++;
        end
        if (hit) begin
            m_pending[co_id] = 1'b0;
            m_count--;
        end
        chk("commit_single_cycle", bus.x_commit_valid_o, 0);
        chk("rej_single_cycle", bus.rej_o, 0);
        if (co_res) check_res(hit, 1'b1, rdata, rrd, co_id);
        else chk("outstanding", bus.outstanding_o, m_count);
    endtask

    initial begin
        logic [2:0] pick;
        rst_n = 1'b0;
        clear_inputs();
        do_reset();

        // reject reuses id 0
        do_issue(1'b0, 1'b0, 0, 1'b0, 3'd0, $urandom, $urandom);
        chk("rej_outstanding", bus.outstanding_o, 0);
        // single MAC on id 0
        do_issue(1'b1, 1'b1, 1, 1'b0, 3'd0, 32'h0102_0304, 32'h0101_0101);
        chk("mac_outstanding_1", bus.outstanding_o, 1);
        do_result(3'd0, 1'b1, 32'h0000_000A);
        chk("mac_outstanding_0", bus.outstanding_o, 0);
        // spurious result
        do_result(3'd5, 1'b1, $urandom);

        // reset in the middle of an issue handshake
        bus.req_valid_i = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        chk("pre_reset_issue_valid", bus.x_issue_valid_o, 1);
        do_reset();

        // fill to the limit, then free id 2 to unblock with id 4
        repeat (4) do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        do_result(3'd2, 1'b1, $urandom);
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        do_result(3'd3, 1'b0, $urandom);
        do_issue(1'b1, 1'b0, 0, 1'b0, 3'd0, $urandom, $urandom);
        do_issue(1'b1, 1'b1, 2, 1'b1, 3'd0, $urandom, $urandom);
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        do_result(3'd4, 1'b1, $urandom);
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        do_result(3'd6, 1'b1, $urandom);
        // next id (1) still pending although below the limit
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        do_result(3'd1, 1'b1, $urandom);
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);

        // random mix
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 99) < 45) begin
                do_issue($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                         $urandom_range(0, 2), $urandom_range(0, 5) == 0,
                         3'($urandom), $urandom, $urandom);
            end else begin
                pick = 3'($urandom);
                if (m_count > 0 && $urandom_range(0, 9) < 8) begin
                    for (int k = 0; k < 8; k++) begin
                        if (m_pending[pick]) break;
                        pick++;
                    end
                end
                do_result(pick, $urandom_range(0, 5) != 0, $urandom);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (m_pending[i]) do_result(3'(i), 1'b1, $urandom);
        end
        chk("drain_outstanding", bus.outstanding_o, 0);

`ifdef INT8_MAC_ISSUER_TIMEOUT_EN
        do_reset();
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        repeat (7) tick();
        chk("timeout_before_limit", bus.timeout_o, 0);
        tick();
        chk("timeout_at_limit", bus.timeout_o, 1);
        do_result(3'd0, 1'b1, $urandom);
        chk("timeout_sticky", bus.timeout_o, 1);
`else
        do_issue(1'b1, 1'b1, 0, 1'b0, 3'd0, $urandom, $urandom);
        repeat (20) tick();
        chk("timeout_tied_low", bus.timeout_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
